// File: rtl/regfile_pkg.sv
// Shared defaults and read-port state type for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 16;
    localparam int PC_IDX_DEF = 15;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: request/response handshake with a latched data word.
// State table:  IDLE | ready for a request    RESP | response valid, data held until acked
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_rd_val,
    input  logic              i_ack,
    output logic              o_rdy,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    rd_state_e         r_state;
    rd_state_e         w_next;
    logic              w_accept;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_rdy    = 1'b1;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_req) begin
                    w_accept = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP: begin
                // The slot frees in the same cycle it is consumed, allowing one result per cycle.
                o_rdy = i_ack;
                if (i_ack) begin
                    if (i_req) w_accept = 1'b1;
                    else       w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_data <= '0;
        else if (w_accept) r_data <= i_rd_val;
    end

    assign o_vld  = (r_state == RESP);
    assign o_data = r_data;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, writeback/PC write priority, CPSR, NRD read ports.
// Optional REGFILE_WR_BYPASS_EN forwards same-cycle writes to reads accepted that cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int PC_IDX = PC_IDX_DEF,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        rd_req,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD-1:0]        rd_rdy,
    output logic [NRD-1:0]        rd_vld,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic [NRD-1:0]        rd_ack,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  pc_we,
    input  logic [DATA_W-1:0]     pc_in,
    output logic [DATA_W-1:0]     pc_out,
    input  logic                  cpsr_we,
    input  logic [DATA_W-1:0]     cpsr_in,
    output logic [DATA_W-1:0]     cpsr_out
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_cpsr;
    logic [DATA_W-1:0] w_rd_val [NRD];

    // Writeback is applied last so it overrides a sequential PC update to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (pc_we) r_regs[PC_A]   <= pc_in;
            if (wr_en) r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_cpsr <= '0;
        else if (cpsr_we) r_cpsr <= cpsr_in;
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            w_rd_val[k] = r_regs[rd_addr[k*AW +: AW]];
`ifdef REGFILE_WR_BYPASS_EN
            if (pc_we && rd_addr[k*AW +: AW] == PC_A) w_rd_val[k] = pc_in;
            if (wr_en && rd_addr[k*AW +: AW] == wr_addr) w_rd_val[k] = wr_data;
`endif
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rdport #(.DATA_W(DATA_W)) u_rdport (
            .clk      (clk),
            .rst      (rst),
            .i_req    (rd_req[k]),
            .i_rd_val (w_rd_val[k]),
            .i_ack    (rd_ack[k]),
            .o_rdy    (rd_rdy[k]),
            .o_vld    (rd_vld[k]),
            .o_data   (rd_data[k*DATA_W +: DATA_W])
        );
    end

    assign pc_out   = r_regs[PC_A];
    assign cpsr_out = r_cpsr;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Clocked, parametrised successor to the core register bank: NREGS x DATA_W architectural registers, NRD independent read ports with valid/ready handshakes, one writeback port, a dedicated PC port and a CPSR register.
- Serves decoder (read ports), writeback (write port), fetch (PC port) and issue (CPSR).
- Replaces level/edge-toggle triggering with synchronous, one-outstanding-per-port transactions.

Parameters:
- DATA_W, 32, register and CPSR width
- NREGS, 16, number of architectural registers; power of two, >= 2
- NRD, 2, number of read ports, 1..4
- PC_IDX, 15, register index aliased to the PC port; < NREGS
- AW, $clog2(NREGS), register address width (derived; do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req  in  NRD  per-port read request
- rd_addr  in  NRD*AW  per-port read address, port k at bits [k*AW +: AW]
- rd_rdy  out  NRD  per-port request accept
- rd_vld  out  NRD  per-port response valid
- rd_data  out  NRD*DATA_W  per-port response data
- rd_ack  in  NRD  per-port response consumed
- wr_en  in  1  writeback write enable
- wr_addr  in  AW  writeback address
- wr_data  in  DATA_W  writeback data
- pc_we  in  1  fetch PC update enable
- pc_in  in  DATA_W  next PC from fetch
- pc_out  out  DATA_W  current PC, equals reg[PC_IDX]
- cpsr_we  in  1  CPSR update enable
- cpsr_in  in  DATA_W  new CPSR
- cpsr_out  out  DATA_W  current CPSR

Behaviour:
- Reset (asynchronous, immediate): all registers, CPSR, rd_vld and rd_data clear to 0; per-port FSMs to IDLE; rd_rdy = all ones once rst deasserts.
- Per-port FSM, IDLE/RESP:
  - IDLE: rd_rdy=1. On rd_req, latch reg[addr], go RESP. rd_vld rises the next cycle (1-cycle latency).
  - RESP: rd_vld=1, rd_data held stable.
    - rd_ack without rd_req: go IDLE.
    - rd_ack with rd_req: accept the new request in the same cycle, stay in RESP, new data next cycle (back-to-back, one result per cycle).
    - No rd_ack: rd_rdy=0 and requests are ignored.
  - rd_rdy in RESP is combinational: rd_rdy = rd_ack.
- Read data is the register value at the start of the accepting cycle. A same-cycle write is not visible unless the optional feature is enabled.
- Writeback: on wr_en, reg[wr_addr] <= wr_data at the clock edge. Writes to any index are legal, including PC_IDX.
- PC port: on pc_we, reg[PC_IDX] <= pc_in.
  - If wr_en and wr_addr==PC_IDX in the same cycle, the writeback port wins (branch overrides sequential fetch).
- pc_out and cpsr_out are registered outputs that reflect the new value the cycle after the update.
- CPSR: on cpsr_we, cpsr <= cpsr_in.
- Multiple read ports may address the same or the PC register simultaneously; all are served independently with no arbitration.
- Out-of-range addresses cannot occur (NREGS is a power of two).
- Reset mid-transaction: outstanding responses are dropped; rd_vld is 0 the cycle after reset.

Optional Feature:
- Macro REGFILE_WR_BYPASS_EN.
- Defined: a read accepted in the same cycle as a write (wr_en, or pc_we for PC_IDX) to the same address returns the new data. Writeback takes priority over PC, matching the write rule.
- Undefined: the read returns the pre-write value. The writer must avoid the hazard.

Decomposition:
- Package regfile_pkg: DATA_W/NREGS defaults, PC_IDX default, rd_state_e enum {IDLE, RESP}.
- Sub-module regfile_rdport, instantiated NRD times: per-port FSM, data latch and handshake. The top holds the storage array, write/PC priority and CPSR.

Test Plan:
- Reset then read: rst pulse, read r3 on port 0 -> rd_vld next cycle, rd_data=0; rst asserted mid-RESP -> rd_vld drops immediately.
- Write/read: wr r5=0xDEADBEEF, read r5 next cycle on both ports -> both return 0xDEADBEEF, 1-cycle latency.
- Backpressure: port 1 request r2, hold rd_ack=0 for 5 cycles -> rd_rdy1=0 and rd_data stable; ack plus new request r4 -> r4 data next cycle.
- PC priority: pc_we pc_in=0x100 and wr_en wr_addr=15 wr_data=0x200 in the same cycle -> pc_out=0x200; pc_we alone 0x104 -> pc_out=0x104 next cycle.
- Bypass: read r7 in the same cycle as wr r7=0x55 -> 0x55 with REGFILE_WR_BYPASS_EN, old value 0 without.
- CPSR: cpsr_we cpsr_in=0xF0000010 -> cpsr_out=0xF0000010 next cycle, held while cpsr_we=0.
